// File: rtl/shared_unit_arbiter_pkg.sv
// Shared definitions for the shared-unit round-robin arbiter.
package shared_unit_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 15;

  // Increment with explicit wrap so non-power-of-2 requester counts stay in range.
  function automatic int wrap_inc(input int value, input int limit);
    return (value + 1 >= limit) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/shared_unit_arbiter_if.sv
// Bundle of requester, shared-unit and response signals around the arbiter.
interface shared_unit_arbiter_if
  import shared_unit_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_in1;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_in2;

  logic              unit_start;
  logic [DATA_W-1:0] unit_in1;
  logic [DATA_W-1:0] unit_in2;
  logic              unit_done;
  logic [DATA_W-1:0] unit_z;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [DATA_W-1:0] rsp_z;
  logic              rsp_err;

  // Arbiter side.
  modport slave (
    input  req_valid, req_in1, req_in2, unit_done, unit_z, rsp_ready,
    output req_ready, unit_start, unit_in1, unit_in2, rsp_valid, rsp_id, rsp_z, rsp_err
  );

  // Requesters, shared unit and response consumer side.
  modport master (
    output req_valid, req_in1, req_in2, unit_done, unit_z, rsp_ready,
    input  req_ready, unit_start, unit_in1, unit_in2, rsp_valid, rsp_id, rsp_z, rsp_err
  );
endinterface

// File: rtl/shared_unit_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_picker
  import shared_unit_arb_pkg::*;
#(
  parameter int N    = DEF_NUM_REQ,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);
  logic [ID_W-1:0] sel;

  // Scan farthest-first so the candidate closest to ptr overwrites the others.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    sel      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sel = ID_W'((int'(ptr) + k) % N);
      if (req[sel]) begin
        grant      = '0;
        grant[sel] = 1'b1;
        grant_id   = sel;
      end
    end
  end
endmodule

// File: rtl/shared_unit_arbiter.sv
// Round-robin controller sharing one two-operand unit among NUM_REQ requesters.
module shared_unit_arbiter
  import shared_unit_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input logic                  clk,
  input logic                  rst_n,
  shared_unit_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;

  localparam int               CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    pick_id;
  logic [NUM_REQ-1:0] pick_grant;
  logic [CNT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]  op1;
  logic [DATA_W-1:0]  op2;
  logic               take;

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req      (bus.req_valid),
    .ptr      (rr_ptr),
    .grant    (pick_grant),
    .grant_id (pick_id)
  );

  // Only IDLE offers a grant; every other state holds all requesters off.
  assign bus.req_ready = (state == ST_IDLE) ? pick_grant : '0;
  assign take          = |(bus.req_ready & bus.req_valid);

  // Operands come straight from their holding registers, so they keep their last value.
  assign bus.unit_in1 = op1;
  assign bus.unit_in2 = op2;

  // Control FSM with operand capture, timeout counting and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      grant_id       <= '0;
      wait_cnt       <= '0;
      op1            <= '0;
      op2            <= '0;
      bus.unit_start <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= '0;
      bus.rsp_z      <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      bus.unit_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take) begin
            grant_id       <= pick_id;
            op1            <= bus.req_in1[pick_id];
            op2            <= bus.req_in2[pick_id];
            bus.unit_start <= 1'b1;
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.unit_done) begin
            bus.rsp_z     <= bus.unit_z;
            bus.rsp_err   <= 1'b0;
            bus.rsp_id    <= grant_id;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else if (wait_cnt == CNT_LAST) begin
            bus.rsp_z     <= '0;
            bus.rsp_err   <= 1'b1;
            bus.rsp_id    <= grant_id;
            bus.rsp_valid <= 1'b1;
            state         <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= ID_W'(wrap_inc(int'(grant_id), NUM_REQ));
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
